d16i_timer: RTL and testbench
=============================

// Module: d16i_timer
// PURPOSE
//  Programmable down-counting timer for D16i. Sits directly downstream of the prescaler.
//  - Drives the prescaler's clk_en and div inputs.
//  - Consumes its clk_out level, detecting rising edges as count ticks.
//  - Raises an interrupt on expiry; CPU access via a 4-register single-cycle bus slave.
// PARAMETERS
//  WIDTH   16   counter/reload/data width
//  ADDR_W  2    register address width (4 registers)
// PORTS
//  clk        in   1      system clock (same clock as prescaler)
//  rst        in   1      reset rst, synchronous, active-high; clock clk
//  presc_in   in   1      prescaler clk_out level
//  presc_en   out  1      prescaler clk_en; =1 while state RUN
//  presc_div  out  4      prescaler div; =CTRL.DIV
//  sel        in   1      bus cycle request (one-cycle pulse)
//  we         in   1      1=write, 0=read; valid with sel
//  addr       in   ADDR_W register select
//  wdata      in   WIDTH  write data
//  rdata      out  WIDTH  read data, registered; valid with ack
//  ack        out  1      one-cycle pulse, exactly 1 clk after sel
//  irq        out  1      level interrupt, registered: STATUS.EXP & CTRL.IE
// BEHAVIOUR
//  Register map:
//   0 CTRL    [0]EN [1]AR(auto-reload) [2]IE [7:4]DIV; other bits read 0
//   1 RELOAD  RW
//   2 COUNT   R=live count; W=load count
//   3 STATUS  [0]EXP sticky, write-1-to-clear
//  Reset: all registers 0, state IDLE.
//   presc_en=0, presc_div=0, rdata=0, ack=0, irq=0, presc_prev=0.
//  Tick detection:
//   - presc_prev <= presc_in every clk.
//   - tick = presc_in & ~presc_prev & (state==RUN).
//   - No synchroniser: same clock domain.
//  FSM (2 states, IDLE/RUN):
//   - IDLE->RUN: write CTRL with EN=1; same edge COUNT<=RELOAD.
//     If that write also carries a new RELOAD? No: RELOAD is a separate address; the current RELOAD is used.
//   - RUN->IDLE: write CTRL with EN=0; COUNT holds its value.
//   - RUN, tick, COUNT!=0: COUNT<=COUNT-1.
//   - RUN, tick, COUNT==0: EXP<=1.
//     - AR=1: COUNT<=RELOAD, stay RUN.
//     - AR=0: COUNT stays 0, CTRL.EN<=0, ->IDLE (one-shot).
//   - Period = (RELOAD+1) ticks. RELOAD=0 gives expiry every tick.
//  Simultaneous events:
//   - Bus write to COUNT in same cycle as tick: write wins, tick lost.
//   - W1C of EXP in same cycle as expiry: set wins, EXP stays 1.
//   - CTRL write EN=1 while already RUN: COUNT not reloaded; AR/IE/DIV update.
//   - DIV change while RUN: takes effect next clk; no count correction.
//  Arithmetic: unsigned WIDTH bits; decrement never wraps (0 handled as expiry).
//  Bus protocol:
//   - ack <= sel.
//   - Reads sample register state on the sel cycle.
//   - Writes commit at the sel edge.
//   - sel with no handshake stall; back-to-back sel allowed.
//  Reset mid-operation: everything returns to reset values next clk; pending ack dropped.
// STRUCTURE
//  Package d16i_timer_pkg:
//   - typedef enum {IDLE,RUN} timer_state_t.
//   - Register address localparams TMR_CTRL/RELOAD/COUNT/STATUS.
//   - CTRL bit-index constants.
//  Sub-module: d16i_edge_det (rising-edge pulse from level, 1 flop).
//  All else in one always_ff plus one always_comb next-state block.
// TESTING
//  1 One-shot: DIV=0, RELOAD=3, CTRL=EN|IE
//    -> EXP and irq rise 8 clk after enable (4 ticks x 2 clk).
//    -> presc_en falls, COUNT=0, CTRL.EN reads 0.
//  2 Auto-reload: RELOAD=2, CTRL=EN|AR, DIV=1
//    -> expiry every 3 ticks (12 clk).
//    -> COUNT sequence 2,1,0,2; state stays RUN.
//  3 W1C race: write STATUS=1 on the exact expiry cycle
//    -> EXP remains 1. A later W1C clears EXP and irq next clk.
//  4 COUNT write collides with tick: write 0x0010
//    -> next read returns 0x0010, not 0x000F.
//  5 Reset mid-run (COUNT=5, EXP=1)
//    -> next clk all regs 0, irq=0, presc_en=0, ack=0.
//  6 Bus: back-to-back reads of addr 0..3 -> ack each cycle, rdata matches model, 1-clk latency.

Source files
------------

// File: rtl/d16i_timer_pkg.sv
// ---------------------------------------------------------------------------
// d16i_timer_pkg
//   Shared types and constants for the D16i down-counting timer.
//   - timer_state_t : IDLE / RUN state of the timer FSM
//   - TMR_*         : register addresses on the 4-register bus slave
//   - CTRL_* / STATUS_* : bit positions inside CTRL and STATUS
// ---------------------------------------------------------------------------
package d16i_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_RELOAD = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AR      = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_DIV_LSB = 4;
  localparam int CTRL_DIV_MSB = 7;

  localparam int STATUS_EXP = 0;

endpackage

// File: rtl/d16i_edge_det.sv
// ---------------------------------------------------------------------------
// d16i_edge_det
//   One-flop rising-edge detector. The level input comes from the prescaler,
//   which runs on the same clock, so no synchroniser is needed.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset (previous level cleared to 0)
//   i_level in  level to watch (prescaler clk_out)
//   o_rise  out 1 while i_level is high and was low on the previous clk
// ---------------------------------------------------------------------------
module d16i_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level every clock, independent of the timer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/d16i_timer.sv
// ---------------------------------------------------------------------------
// d16i_timer
//   Programmable down-counting timer sitting behind the D16i prescaler.
//   Counts rising edges of the prescaler output while running, raises a
//   sticky expiry flag and a level interrupt, and supports one-shot or
//   auto-reload operation. Configured through a 4-register bus slave.
// Ports:
//   clk          in  system clock (shared with the prescaler)
//   rst          in  synchronous active-high reset
//   i_presc_in   in  prescaler clk_out level
//   o_presc_en   out prescaler clk_en, high while RUN
//   o_presc_div  out prescaler div, mirrors CTRL.DIV
//   i_sel        in  one-cycle bus request
//   i_we         in  1 = write, 0 = read (valid with i_sel)
//   i_addr       in  register select (CTRL/RELOAD/COUNT/STATUS)
//   i_wdata      in  write data
//   o_rdata      out registered read data, valid with o_ack
//   o_ack        out one-cycle acknowledge, one clk after i_sel
//   o_irq        out registered level interrupt = STATUS.EXP & CTRL.IE
// ---------------------------------------------------------------------------
module d16i_timer
  import d16i_timer_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_presc_in,
  output logic              o_presc_en,
  output logic [3:0]        o_presc_div,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_ack,
  output logic              o_irq
);

  timer_state_t     r_state;
  logic             r_ar;
  logic             r_ie;
  logic [3:0]       r_div;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_count;
  logic             r_exp;

  timer_state_t     w_nextState;
  logic             w_nextAr;
  logic             w_nextIe;
  logic [3:0]       w_nextDiv;
  logic [WIDTH-1:0] w_nextReload;
  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextExp;
  logic             w_rise;
  logic             w_tick;
  logic             w_wr;
  logic             w_wrCount;
  logic             w_expire;
  logic             w_w1c;
  logic [WIDTH-1:0] w_rdMux;

  d16i_edge_det u_edgeDet (
    .clk     (clk),
    .rst     (rst),
    .i_level (i_presc_in),
    .o_rise  (w_rise)
  );

  assign w_tick      = w_rise & (r_state == RUN);
  assign w_wr        = i_sel & i_we;
  assign w_wrCount   = w_wr & (i_addr == TMR_COUNT);
  assign o_presc_en  = (r_state == RUN);
  assign o_presc_div = r_div;

  // Next-state logic. The tick is applied first, then bus writes override.
  // A COUNT write suppresses the tick entirely; CTRL writes decide the final
  // state even if the same tick expired a one-shot; a W1C never beats a
  // simultaneous expiry.
  always_comb begin
    w_nextState  = r_state;
    w_nextAr     = r_ar;
    w_nextIe     = r_ie;
    w_nextDiv    = r_div;
    w_nextReload = r_reload;
    w_nextCount  = r_count;
    w_expire     = 1'b0;
    w_w1c        = 1'b0;

    if (w_tick && !w_wrCount) begin
      if (r_count != '0) begin
        w_nextCount = r_count - WIDTH'(1);
      end else begin
        w_expire = 1'b1;
        if (r_ar) begin
          w_nextCount = r_reload;
        end else begin
          w_nextState = IDLE;
        end
      end
    end

    if (w_wr) begin
      case (i_addr)
        TMR_CTRL: begin
          w_nextAr  = i_wdata[CTRL_AR];
          w_nextIe  = i_wdata[CTRL_IE];
          w_nextDiv = i_wdata[CTRL_DIV_MSB:CTRL_DIV_LSB];
          if (i_wdata[CTRL_EN]) begin
            w_nextState = RUN;
            if (r_state == IDLE) begin
              w_nextCount = r_reload;
            end
          end else begin
            w_nextState = IDLE;
          end
        end
        TMR_RELOAD: w_nextReload = i_wdata;
        TMR_COUNT:  w_nextCount  = i_wdata;
        TMR_STATUS: w_w1c        = i_wdata[STATUS_EXP];
        default:    ;
      endcase
    end

    w_nextExp = (r_exp & ~w_w1c) | w_expire;
  end

  // Read multiplexer: samples the register state as seen on the sel cycle.
  // CTRL.EN is not stored separately; it is exactly "state is RUN".
  always_comb begin
    w_rdMux = '0;
    case (i_addr)
      TMR_CTRL: begin
        w_rdMux[CTRL_EN]                   = (r_state == RUN);
        w_rdMux[CTRL_AR]                   = r_ar;
        w_rdMux[CTRL_IE]                   = r_ie;
        w_rdMux[CTRL_DIV_MSB:CTRL_DIV_LSB] = r_div;
      end
      TMR_RELOAD: w_rdMux = r_reload;
      TMR_COUNT:  w_rdMux = r_count;
      TMR_STATUS: w_rdMux[STATUS_EXP] = r_exp;
      default:    ;
    endcase
  end

  // State and bus-side registers. The interrupt is computed from next-state
  // values so it rises and falls on the same edge as STATUS.EXP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ar     <= 1'b0;
      r_ie     <= 1'b0;
      r_div    <= '0;
      r_reload <= '0;
      r_count  <= '0;
      r_exp    <= 1'b0;
      o_rdata  <= '0;
      o_ack    <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_ar     <= w_nextAr;
      r_ie     <= w_nextIe;
      r_div    <= w_nextDiv;
      r_reload <= w_nextReload;
      r_count  <= w_nextCount;
      r_exp    <= w_nextExp;
      o_ack    <= i_sel;
      if (i_sel && !i_we) begin
        o_rdata <= w_rdMux;
      end
      o_irq    <= w_nextExp & w_nextIe;
    end
  end

endmodule

// File: tb/tb_d16i_timer.sv
// ---------------------------------------------------------------------------
// tb_d16i_timer
//   Self-checking bench for d16i_timer. A behavioural prescaler drives the
//   timer's tick input, and a register-level reference model predicts every
//   output each cycle. Directed scenarios cover one-shot, auto-reload, races
//   and reset; a randomized phase then exercises the bus freely.
// ---------------------------------------------------------------------------
module tb_d16i_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        presc_in = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        presc_en;
  logic [3:0]  presc_div;
  logic [15:0] rdata;
  logic        ack;
  logic        irq;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model state (plain integers and flags)
  bit          mRun, mAr, mIe, mExp, mPrev, mAck;
  int          mCount, mReload, mDiv;
  logic [15:0] mRdata;

  // Behavioural prescaler: toggles its output every (div+1) clocks while enabled
  int pCnt;
  bit pLevel;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  d16i_timer #(.WIDTH(16), .ADDR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_presc_in  (presc_in),
    .o_presc_en  (presc_en),
    .o_presc_div (presc_div),
    .i_sel       (sel),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_ack       (ack),
    .o_irq       (irq)
  );

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: one clock of timer behaviour from its register-level rules
  task automatic modelStep(input bit s, input bit w, input int a, input int d, input bit lvl);
    bit tick;
    bit expire;
    bit wasRun;
    int rd;
    wasRun = mRun;
    mAck   = s;
    if (s && !w) begin
      case (a)
        0:       rd = mRun + 2 * mAr + 4 * mIe + 16 * mDiv;
        1:       rd = mReload;
        2:       rd = mCount;
        default: rd = mExp;
      endcase
      mRdata = rd[15:0];
    end
    tick   = lvl && !mPrev && mRun;
    mPrev  = lvl;
    expire = 1'b0;
    if (tick && !(s && w && a == 2)) begin
      if (mCount > 0) begin
        mCount = mCount - 1;
      end else begin
        expire = 1'b1;
        if (mAr) mCount = mReload;
        else     mRun = 1'b0;
      end
    end
    if (s && w) begin
      case (a)
        0: begin
          mAr  = d[1];
          mIe  = d[2];
          mDiv = (d / 16) % 16;
          if (d[0]) begin
            if (!wasRun) mCount = mReload;
            mRun = 1'b1;
          end else begin
            mRun = 1'b0;
          end
        end
        1:       mReload = d % 65536;
        2:       mCount  = d % 65536;
        default: if (d[0]) mExp = 1'b0;
      endcase
    end
    if (expire) mExp = 1'b1;
  endtask

  // One bus cycle: drive inputs, clock, advance model and prescaler, check outputs
  task automatic applyStimulus(input bit s, input bit w, input int a, input int d);
    bit oldRun;
    int oldDiv;
    bit lvl;
    sel    = s;
    we     = w;
    addr   = a[1:0];
    wdata  = d[15:0];
    lvl    = presc_in;
    oldRun = mRun;
    oldDiv = mDiv;
    @(posedge clk);
    #1;
    cyc++;
    modelStep(s, w, a, d, lvl);
    if (!oldRun) begin
      pCnt   = 0;
      pLevel = 1'b0;
    end else if (pCnt == oldDiv) begin
      pCnt   = 0;
      pLevel = ~pLevel;
    end else begin
      pCnt++;
    end
    presc_in = pLevel;
    checkOutput("ack", ack, mAck);
    checkOutput("irq", irq, mExp && mIe);
    checkOutput("presc_en", presc_en, mRun);
    checkOutput("presc_div", presc_div, mDiv);
    if (mAck) checkOutput("rdata", rdata, mRdata);
    sel = 1'b0;
    we  = 1'b0;
  endtask

  // Synchronous reset cycle with a read in flight, whose ack must be dropped
  task automatic doReset();
    rst  = 1'b1;
    sel  = 1'b1;
    we   = 1'b0;
    addr = 2'd2;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    sel = 1'b0;
    {mRun, mAr, mIe, mExp, mPrev, mAck} = '0;
    mCount  = 0;
    mReload = 0;
    mDiv    = 0;
    mRdata  = '0;
    pCnt    = 0;
    pLevel  = 1'b0;
    presc_in = 1'b0;
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_irq", irq, 0);
    checkOutput("rst_presc_en", presc_en, 0);
    checkOutput("rst_rdata", rdata, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0);
  endtask

  task automatic readCheck(input int a, input int expVal, input string tag);
    applyStimulus(1'b1, 1'b0, a, 0);
    checkOutput(tag, rdata, expVal);
  endtask

  // Idle until irq reaches the wanted level, with a bounded cycle budget
  task automatic waitIrq(input bit lvl, input int maxCyc, output int n);
    n = 0;
    while (irq !== lvl && n < maxCyc) begin
      applyStimulus(1'b0, 1'b0, 0, 0);
      n++;
    end
    if (irq !== lvl) checkOutput("irq_timeout", irq, lvl);
  endtask

  // Main sequence: directed scenarios followed by randomized traffic
  initial begin
    int n;
    int t0;

    doReset();
    readCheck(0, 0, "rst_ctrl");
    readCheck(1, 0, "rst_reload");
    readCheck(2, 0, "rst_count");
    readCheck(3, 0, "rst_status");

    // One-shot, DIV=0: 4 ticks of 2 clocks each
    applyStimulus(1'b1, 1'b1, 1, 3);
    applyStimulus(1'b1, 1'b1, 0, 16'h0005);
    waitIrq(1'b1, 40, n);
    checkOutput("t1_latency", n, 8);
    checkOutput("t1_presc_en", presc_en, 0);
    readCheck(2, 0, "t1_count");
    readCheck(0, 16'h0004, "t1_ctrl");
    readCheck(3, 1, "t1_status");
    idle(3);

    // W1C racing an expiry: the set wins, a later clear drops irq
    applyStimulus(1'b1, 1'b1, 3, 1);
    applyStimulus(1'b1, 1'b1, 1, 3);
    applyStimulus(1'b1, 1'b1, 0, 16'h0007);
    idle(7);
    applyStimulus(1'b1, 1'b1, 3, 1);
    checkOutput("t3_race_irq", irq, 1);
    applyStimulus(1'b1, 1'b1, 3, 1);
    checkOutput("t3_clear_irq", irq, 0);
    readCheck(3, 0, "t3_status");
    applyStimulus(1'b1, 1'b1, 0, 0);
    idle(4);

    // Auto-reload, DIV=1: tick every 4 clocks, expiry every 12
    applyStimulus(1'b1, 1'b1, 1, 2);
    applyStimulus(1'b1, 1'b1, 0, 16'h0017);
    waitIrq(1'b1, 60, n);
    checkOutput("t2_first", n, 11);
    t0 = cyc;
    applyStimulus(1'b1, 1'b1, 3, 1);
    waitIrq(1'b1, 60, n);
    checkOutput("t2_period", cyc - t0, 12);
    checkOutput("t2_running", presc_en, 1);
    readCheck(2, 2, "t2_reload");
    idle(3);
    readCheck(2, 1, "t2_count1");
    applyStimulus(1'b1, 1'b1, 0, 0);
    applyStimulus(1'b1, 1'b1, 3, 1);
    idle(4);

    // COUNT write on the same edge as a tick: the written value survives
    applyStimulus(1'b1, 1'b1, 1, 16'h0100);
    applyStimulus(1'b1, 1'b1, 0, 16'h0003);
    idle(1);
    applyStimulus(1'b1, 1'b1, 2, 16'h0010);
    readCheck(2, 16'h0010, "t4_collide");
    applyStimulus(1'b1, 1'b1, 0, 0);
    idle(4);

    // Reset in the middle of a run with COUNT=5 and EXP set
    applyStimulus(1'b1, 1'b1, 1, 0);
    applyStimulus(1'b1, 1'b1, 0, 16'h0007);
    waitIrq(1'b1, 20, n);
    applyStimulus(1'b1, 1'b1, 2, 5);
    doReset();
    readCheck(0, 0, "t5_ctrl");
    readCheck(1, 0, "t5_reload");
    readCheck(2, 0, "t5_count");
    readCheck(3, 0, "t5_status");

    // Randomized traffic, including back-to-back read bursts of all registers
    for (int i = 0; i < 400; i++) begin
      int r;
      int a;
      int d;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        for (int j = 0; j < 4; j++) applyStimulus(1'b1, 1'b0, j, 0);
      end else if (r < 5) begin
        applyStimulus(1'b0, 1'b0, 0, 0);
      end else begin
        a = $urandom_range(0, 3);
        case (a)
          0:       d = $urandom_range(0, 2) * 16 + $urandom_range(0, 7);
          3:       d = $urandom_range(0, 1);
          default: d = $urandom_range(0, 5);
        endcase
        applyStimulus(1'b1, ($urandom_range(0, 1) == 1), a, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
